// File: rtl/l1_dcache_req_ctrl_pkg.sv
// Shared types for the L1 dcache request controller: FSM states, latched op type,
// watchdog counter width and the op-pulse priority decoder.
package l1_dcache_ctrl_pkg;

   localparam int CNT_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_TRANS     = 3'd1,
      ST_REQ       = 3'd2,
      ST_WAIT_RESP = 3'd3,
      ST_DONE      = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      OP_NONE   = 2'b00,
      OP_LOAD   = 2'b01,
      OP_STORE  = 2'b10,
      OP_ATOMIC = 2'b11
   } op_e;

   // Simultaneous issue pulses resolve atomic > store > load.
   function automatic op_e op_decode(input logic atm, input logic st, input logic ld);
      if (atm)     return OP_ATOMIC;
      else if (st) return OP_STORE;
      else if (ld) return OP_LOAD;
      else         return OP_NONE;
   endfunction

endpackage

// File: rtl/l1_dcache_req_ctrl_if.sv
// Core / MMU / dcache handshake bundle of the request controller.
// slave = controller side, master = environment side.
interface l1_dcache_req_ctrl_if;
   logic       is_store_i;
   logic       is_load_i;
   logic       is_op_atm_i;
   logic       kill_i;
   logic       dtlb_hit_i;
   logic       dtlb_ex_i;
   logic       dcache_gnt_i;
   logic       dcache_rvalid_i;
   logic       ready_o;
   logic       translation_req_o;
   logic       mem_req_valid_o;
   logic       str_rdy_o;
   logic [1:0] op_type_o;
   logic       done_o;
   logic       ex_o;
   logic       timeout_o;
   logic [2:0] state_o;

   modport slave (
      input  is_store_i, is_load_i, is_op_atm_i, kill_i,
             dtlb_hit_i, dtlb_ex_i, dcache_gnt_i, dcache_rvalid_i,
      output ready_o, translation_req_o, mem_req_valid_o, str_rdy_o,
             op_type_o, done_o, ex_o, timeout_o, state_o
   );

   modport master (
      output is_store_i, is_load_i, is_op_atm_i, kill_i,
             dtlb_hit_i, dtlb_ex_i, dcache_gnt_i, dcache_rvalid_i,
      input  ready_o, translation_req_o, mem_req_valid_o, str_rdy_o,
             op_type_o, done_o, ex_o, timeout_o, state_o
   );
endinterface

// File: rtl/l1_dcache_req_ctrl.sv
// L1 dcache request controller: issue -> MMU translation -> dcache request -> response.
// Optional watchdog abort enabled by defining L1_DCACHE_CTRL_TIMEOUT_EN.
module l1_dcache_req_ctrl
   import l1_dcache_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   l1_dcache_req_ctrl_if.slave  bus
);

   state_e r_state, w_nxt;
   op_e    r_op;
   logic   r_killed, w_killed_nxt;
   logic   r_ready, r_trans, r_memv, r_strrdy, r_done, r_ex;
   logic   w_ex, w_to, w_tmo, w_issue, w_store, w_kill_any;

   assign w_issue    = bus.is_store_i | bus.is_load_i | bus.is_op_atm_i;
   assign w_store    = (r_op == OP_STORE);
   assign w_kill_any = r_killed | bus.kill_i;

`ifdef L1_DCACHE_CTRL_TIMEOUT_EN
   logic [CNT_W-1:0] r_cnt;
   logic             r_to;
   assign w_tmo         = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign bus.timeout_o = r_to;
`else
   logic w_unused_cfg;
   assign w_unused_cfg  = ^{TIMEOUT_CYCLES, w_to};
   assign w_tmo         = 1'b0;
   assign bus.timeout_o = 1'b0;
`endif

   always_comb begin
      w_nxt        = r_state;
      w_killed_nxt = r_killed;
      w_ex         = 1'b0;
      w_to         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_killed_nxt = 1'b0;
            if (w_issue) w_nxt = ST_TRANS;
         end
         ST_TRANS: begin
            if (bus.kill_i)          w_nxt = ST_IDLE;
            else if (bus.dtlb_ex_i)  begin w_nxt = ST_DONE; w_ex = 1'b1; end
            else if (bus.dtlb_hit_i) w_nxt = ST_REQ;
            else if (w_tmo)          begin w_nxt = ST_DONE; w_to = 1'b1; end
         end
         ST_REQ: begin
            // A grant already issued to the dcache cannot be taken back, so it beats kill.
            if (bus.dcache_gnt_i) begin
               if (w_store) w_nxt = bus.kill_i ? ST_IDLE : ST_DONE;
               else begin
                  w_nxt        = ST_WAIT_RESP;
                  w_killed_nxt = bus.kill_i;
               end
            end
            else if (bus.kill_i) w_nxt = ST_IDLE;
            else if (w_tmo)      begin w_nxt = ST_DONE; w_to = 1'b1; end
         end
         ST_WAIT_RESP: begin
            if (bus.kill_i) w_killed_nxt = 1'b1;
            if (bus.dcache_rvalid_i || w_tmo) begin
               w_nxt = w_kill_any ? ST_IDLE : ST_DONE;
               w_to  = ~bus.dcache_rvalid_i;
            end
         end
         ST_DONE: w_nxt = ST_IDLE;
         default: w_nxt = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they are registered yet aligned to it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= ST_IDLE;
         r_op     <= OP_NONE;
         r_killed <= 1'b0;
         r_ready  <= 1'b1;
         r_trans  <= 1'b0;
         r_memv   <= 1'b0;
         r_strrdy <= 1'b0;
         r_done   <= 1'b0;
         r_ex     <= 1'b0;
`ifdef L1_DCACHE_CTRL_TIMEOUT_EN
         r_cnt    <= '0;
         r_to     <= 1'b0;
`endif
      end else begin
         r_state  <= w_nxt;
         r_killed <= w_killed_nxt;
         r_ready  <= (w_nxt == ST_IDLE);
         r_trans  <= (w_nxt == ST_TRANS);
         r_memv   <= (w_nxt == ST_REQ);
         r_strrdy <= (w_nxt == ST_REQ) || (w_nxt == ST_WAIT_RESP);
         r_done   <= (w_nxt == ST_DONE);
         r_ex     <= (w_nxt == ST_DONE) && w_ex;
         if (w_nxt == ST_IDLE)
            r_op <= OP_NONE;
         else if (r_state == ST_IDLE && w_issue)
            r_op <= op_decode(bus.is_op_atm_i, bus.is_store_i, bus.is_load_i);
`ifdef L1_DCACHE_CTRL_TIMEOUT_EN
         r_to <= (w_nxt == ST_DONE) && w_to;
         if (w_nxt == ST_TRANS && r_state != ST_TRANS)
            r_cnt <= '0;
         else if (r_state == ST_TRANS || r_state == ST_REQ || r_state == ST_WAIT_RESP)
            r_cnt <= r_cnt + 1'b1;
`endif
      end
   end

   assign bus.ready_o           = r_ready;
   assign bus.translation_req_o = r_trans;
   assign bus.mem_req_valid_o   = r_memv;
   assign bus.str_rdy_o         = r_strrdy;
   assign bus.op_type_o         = r_op;
   assign bus.done_o            = r_done;
   assign bus.ex_o              = r_ex;
   assign bus.state_o           = r_state;

endmodule
